// File: rtl/rotating_square_pkg.sv
// Shared definitions for the rotating-square display animator.
//   SSEG_*       : active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}
//   dir_e        : rotation direction, encoded to match the cw input
//   square_loc_t : which digit holds the square and whether it is the upper one
//   pos_to_loc() : maps a perimeter position onto a digit/half pair
package rotating_square_pkg;

  localparam logic [7:0] SSEG_UPPER = 8'h9C;  // a,b,f,g lit
  localparam logic [7:0] SSEG_LOWER = 8'hA3;  // c,d,e,g lit
  localparam logic [7:0] SSEG_BLANK = 8'hFF;  // everything dark, dp included

  typedef enum logic {
    DIR_CCW = 1'b0,
    DIR_CW  = 1'b1
  } dir_e;

  typedef struct packed {
    logic        upper;
    logic [15:0] digit;
  } square_loc_t;

  // Positions 0..n-1 walk the upper squares from the leftmost digit (n-1)
  // to the rightmost (0); positions n..2n-1 walk the lower squares back
  // from the rightmost digit to the leftmost.
  function automatic square_loc_t pos_to_loc(input int p, input int n);
    square_loc_t loc;
    if (p < n) begin
      loc.upper = 1'b1;
      loc.digit = 16'(n - 1 - p);
    end else begin
      loc.upper = 1'b0;
      loc.digit = 16'(p - n);
    end
    return loc;
  endfunction

endpackage

// File: rtl/disp_mux_n.sv
// Time-multiplexer for an N-digit active-low seven-segment display.
//   clk, reset : clock, asynchronous active-high reset
//   en         : 1 = drive the selected digit, 0 = blank everything
//   patterns   : per-digit segment patterns, digit i in bits [8*i +: 8]
//   an         : registered digit enables, active-low, an[0] rightmost
//   sseg       : registered segment lines, active-low
module disp_mux_n
  import rotating_square_pkg::*;
#(
  parameter int N_DIG         = 4,
  parameter int REFRESH_TICKS = 50_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [8*N_DIG-1:0]   patterns,
  output logic [N_DIG-1:0]     an,
  output logic [7:0]           sseg
);

  localparam int RC_W  = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int DIG_W = $clog2(N_DIG);

  logic [RC_W-1:0]  ref_cnt;
  logic [DIG_W-1:0] dig;
  logic [7:0]       dig_pattern;

  // The refresh scan keeps running while the display is blanked so the
  // digit phase is independent of en.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt <= '0;
      dig     <= '0;
    end else if (ref_cnt == RC_W'(REFRESH_TICKS - 1)) begin
      ref_cnt <= '0;
      dig     <= (dig == DIG_W'(N_DIG - 1)) ? '0 : dig + DIG_W'(1);
    end else begin
      ref_cnt <= ref_cnt + RC_W'(1);
    end
  end

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    dig_pattern = SSEG_BLANK;
    for (int i = 0; i < N_DIG; i++) begin
      if (int'(dig) == i) dig_pattern = patterns[8*i +: 8];
    end
  end

  // Output register: the pins change exactly one cycle after dig, the
  // pattern or en change, and never glitch between digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= '1;
      sseg <= SSEG_BLANK;
    end else if (en) begin
      an   <= ~(N_DIG'(1) << dig);
      sseg <= dig_pattern;
    end else begin
      an   <= '1;
      sseg <= SSEG_BLANK;
    end
  end

endmodule

// File: rtl/rotating_square_n.sv
// Rotating-square animator for an N-digit active-low seven-segment display.
// A square circulates the display perimeter: upper squares left to right,
// then lower squares right to left (clockwise), or the reverse.
//   clk, reset : clock, asynchronous active-high reset
//   en         : 1 = animate and display, 0 = freeze position and blank
//   cw         : 1 = position increments, 0 = position decrements
//   spd        : step period is STEP_TICKS << spd clock cycles
//   an, sseg   : registered active-low digit enables / segments
//   pos        : current perimeter position 0..2*N_DIG-1
module rotating_square_n
  import rotating_square_pkg::*;
#(
  parameter int N_DIG         = 4,
  parameter int STEP_TICKS    = 50_000_000,
  parameter int REFRESH_TICKS = 50_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         cw,
  input  logic [1:0]                   spd,
  output logic [N_DIG-1:0]             an,
  output logic [7:0]                   sseg,
  output logic [$clog2(2*N_DIG)-1:0]   pos
);

  localparam int POS_W   = $clog2(2*N_DIG);
  localparam int POS_MAX = 2*N_DIG - 1;
  // Wide enough for the longest period, STEP_TICKS << 3.
  localparam int CNT_W   = $clog2(STEP_TICKS*8) + 1;

  logic [CNT_W-1:0]   step_cnt;
  logic [CNT_W-1:0]   step_cnt_nxt;
  logic [CNT_W-1:0]   period_m1;
  logic               step;
  logic [POS_W-1:0]   pos_nxt;
  square_loc_t        loc;
  logic [8*N_DIG-1:0] patterns;

  assign period_m1 = (CNT_W'(STEP_TICKS) << spd) - CNT_W'(1);

  // Step timer. The >= comparison means that if spd drops below the
  // current count, the step fires on the very next cycle.
  always_comb begin
    step         = en && (step_cnt >= period_m1);
    step_cnt_nxt = step_cnt + CNT_W'(1);
    if (!en || step) step_cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_cnt <= '0;
    else       step_cnt <= step_cnt_nxt;
  end

  // Position state: next-state logic, then the state register itself,
  // which is also the debug output.
  always_comb begin
    pos_nxt = pos;
    if (step) begin
      if (dir_e'(cw) == DIR_CW)
        pos_nxt = (pos == POS_W'(POS_MAX)) ? '0 : pos + POS_W'(1);
      else
        pos_nxt = (pos == '0) ? POS_W'(POS_MAX) : pos - POS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pos <= '0;
    else       pos <= pos_nxt;
  end

  // One digit carries the square; all others stay blank.
  always_comb begin
    loc      = pos_to_loc(int'(pos), N_DIG);
    patterns = {N_DIG{SSEG_BLANK}};
    for (int i = 0; i < N_DIG; i++) begin
      if (int'(loc.digit) == i)
        patterns[8*i +: 8] = loc.upper ? SSEG_UPPER : SSEG_LOWER;
    end
  end

  disp_mux_n #(
    .N_DIG         (N_DIG),
    .REFRESH_TICKS (REFRESH_TICKS)
  ) u_disp_mux (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .patterns (patterns),
    .an       (an),
    .sseg     (sseg)
  );

endmodule

// File: tb/tb_rotating_square_n.sv
// Self-checking bench for rotating_square_n (N_DIG=4, STEP_TICKS=4,
// REFRESH_TICKS=2). A reference model predicts every registered output
// after each rising edge and queues it; a monitor on the falling edge pops
// and compares. Directed phases follow the block's key scenarios, then a
// randomized phase exercises en/cw/spd/reset mixes.
module tb_rotating_square_n;

  localparam int N  = 4;
  localparam int ST = 4;
  localparam int RT = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b1;
  logic       cw    = 1'b1;
  logic [1:0] spd   = 2'd0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [2:0] pos;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    logic [2:0] pos;
  } exp_t;

  exp_t sb_q[$];

  // Reference state: perimeter position, enabled cycles since the last
  // step, and edges since reset (the refresh phase is derived from it).
  int m_pos     = 0;
  int m_elapsed = 0;
  int m_k       = 0;

  rotating_square_n #(
    .N_DIG         (N),
    .STEP_TICKS    (ST),
    .REFRESH_TICKS (RT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .cw    (cw),
    .spd   (spd),
    .an    (an),
    .sseg  (sseg),
    .pos   (pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Segment pattern digit d shows when the square is at position p.
  function automatic logic [7:0] ref_seg(input int p, input int d);
    if (p < N) return (d == N - 1 - p) ? 8'h9C : 8'hFF;
    return (d == p - N) ? 8'hA3 : 8'hFF;
  endfunction

  // Reference model: runs on each rising edge with the pre-edge inputs.
  always @(posedge clk) begin
    exp_t e;
    int   d;
    int   period;
    if (reset) begin
      m_pos     = 0;
      m_elapsed = 0;
      m_k       = 0;
      e.an      = 4'hF;
      e.sseg    = 8'hFF;
    end else begin
      d      = (m_k / RT) % N;
      period = ST << spd;
      if (en) begin
        e.an   = ~(4'b0001 << d);
        e.sseg = ref_seg(m_pos, d);
        if (m_elapsed + 1 >= period) begin
          m_pos     = cw ? (m_pos + 1) % (2*N) : (m_pos + 2*N - 1) % (2*N);
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end else begin
        e.an      = 4'hF;
        e.sseg    = 8'hFF;
        m_elapsed = 0;
      end
      m_k++;
    end
    e.pos = 3'(m_pos);
    sb_q.push_back(e);
  end

  // Monitor: compares the DUT against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got no prediction required one at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      check("an",   32'(an),   32'(e.an));
      check("sseg", 32'(sseg), 32'(e.sseg));
      check("pos",  32'(pos),  32'(e.pos));
    end
  end

  // Inputs change shortly after the falling edge, clear of both the
  // monitor and the rising edge.
  task automatic step_in();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pos(input int target, input int budget);
    for (int i = 0; i < budget && m_pos != target; i++) step_in();
    if (m_pos != target) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: got %0d required %0d within %0d cycles", m_pos, target, budget);
    end
  endtask

  task automatic wait_step(input int budget);
    int start;
    start = m_pos;
    for (int i = 0; i < budget && m_pos == start; i++) step_in();
    if (m_pos == start) begin
      checks++;
      errors++;
      $display("FAIL wait_step: got no step required one within %0d cycles", budget);
    end
  endtask

  initial begin
    // Reset held for 3 edges with en=1, then released.
    repeat (3) @(posedge clk);
    step_in();
    reset = 1'b0;

    // Clockwise at the fastest rate: full lap and a bit.
    repeat (40) step_in();

    // Counter-clockwise from position 0: 7, then 6.
    wait_pos(0, 40);
    cw = 1'b0;
    repeat (8) step_in();

    // Freeze at position 3 for 20 cycles, then resume clockwise.
    wait_pos(3, 40);
    en = 1'b0;
    cw = 1'b1;
    repeat (20) step_in();
    en = 1'b1;
    repeat (10) step_in();

    // Slowest-but-one rate, then drop spd with the counter at 10.
    spd = 2'd2;
    wait_step(40);
    repeat (10) step_in();
    spd = 2'd0;
    repeat (12) step_in();

    // Reset asserted between edges must act immediately.
    repeat (3) step_in();
    reset = 1'b1;
    #1;
    check("async_rst_an",   32'(an),   32'hF);
    check("async_rst_sseg", 32'(sseg), 32'hFF);
    check("async_rst_pos",  32'(pos),  32'h0);
    repeat (2) step_in();
    reset = 1'b0;

    // Randomized mixes of en, cw, spd and occasional reset.
    for (int i = 0; i < 600; i++) begin
      step_in();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      if ($urandom_range(0, 15) == 0) en  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 23) == 0) cw  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) spd = 2'($urandom_range(0, 3));
    end

    step_in();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
